ov7670_capture_fifo_writer: RTL and testbench
=============================================

// Module: ov7670_capture_fifo_writer
// PURPOSE
//  Captures OV7670 8-bit RGB565 byte stream (VSYNC/HREF/D[7:0]) in the camera PCLK domain.
//  Packs byte pairs into 16-bit pixels and pushes them into the write side of the async FIFO
//  whose read side feeds the VGA output stage. Discards start-up frames. Flags overflow and
//  malformed line/frame geometry.
// PARAMETERS
//  SKIP_FRAMES  2    vsync pulses discarded after reset before capture begins (sensor settle)
//  H_ACTIVE     640  expected pixels per line (2*H_ACTIVE bytes per HREF high)
//  V_ACTIVE     480  expected lines per frame
// PORTS
//  clk         in   1   camera PCLK; all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  cam_vsync   in   1   sensor VSYNC, active-high pulse marks frame boundary
//  cam_href    in   1   sensor HREF, high while line bytes are valid
//  cam_data    in   8   sensor data byte
//  full_fifo   in   1   async FIFO write-side full
//  wr_en       out  1   FIFO write strobe, one cycle per pixel
//  dout        out  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}; valid while wr_en=1
//  pixel_x     out  12  column of last captured pixel
//  pixel_y     out  12  current line index in frame
//  capturing   out  1   high in S_CAPTURE
//  frame_done  out  1   one-cycle pulse at end of each captured frame
//  line_err    out  1   one-cycle pulse: line byte count != 2*H_ACTIVE
//  frame_err   out  1   one-cycle pulse with frame_done: line count != V_ACTIVE
//  overflow    out  1   sticky: a pixel was dropped because full_fifo=1; cleared only by rst
// BEHAVIOUR
//  - Reset: every output 0; state S_SKIP; skip_cnt, byte phase, counters 0. Reset mid-frame
//    abandons the frame; no partial pixel is written afterwards.
//  - Inputs registered once (vs_q, href_q, data_q); edges from vs_q vs vs_qq.
//  - S_SKIP: on each vs rise: if skip_cnt==SKIP_FRAMES -> S_VSYNC, else skip_cnt++.
//    SKIP_FRAMES=0 => first vs rise starts capture.
//  - S_VSYNC: wait vs_q=0 -> S_CAPTURE; clear pixel_y, line byte count, phase.
//  - S_CAPTURE: href_q rise resets phase to HI and byte count. Each cycle with href_q=1:
//    phase HI latches data_q as hi byte; phase LO forms {hi,data_q}, phase toggles each byte.
//    On LO byte: if !full_fifo, wr_en=1, dout={hi,data_q} next cycle; else drop, overflow<=1.
//    Latency: LO byte sampled at pin on edge k -> wr_en/dout high in cycle after edge k+1.
//    pixel_x = index of written/dropped pixel, saturates at 4095.
//    href_q fall: if byte count != 2*H_ACTIVE pulse line_err (odd trailing HI byte dropped);
//    pixel_y++ (saturating).
//  - vs rise in S_CAPTURE: pulse frame_done; frame_err if pixel_y != V_ACTIVE; -> S_VSYNC.
//    Priority: vs rise wins over any href activity that cycle; pending HI byte discarded, no
//    line_err for a line cut by vs.
//  - wr_en never asserted outside S_CAPTURE or while full_fifo=1 in the write cycle.
//  - Widths: byte count 13 bits; skip_cnt ceil(log2(SKIP_FRAMES+1)), min 1 bit.
// STRUCTURE
//  - Shared package/include: state encodings (S_SKIP,S_VSYNC,S_CAPTURE), default H_ACTIVE/
//    V_ACTIVE shared with VGA timing core, RGB565 field positions.
//  - One sub-module: rgb565_byte_packer (phase toggle, hi latch, word assembly, href-rise clear).
//    FSM, counters and error flags stay in top.
// TESTING
//  - SKIP_FRAMES=2, three 640x480 frames, FIFO never full -> no wr_en in frames 0,1;
//    exactly 307200 writes in frame 2, frame_done once, no errors.
//  - Bytes 0xF8,0x1F on a line -> dout=16'hF81F; bytes 0x07,0xE0 -> 16'h07E0, in order.
//  - full_fifo=1 for pixels 10..12 of line 0 -> 3 writes missing, overflow=1 held until rst,
//    pixel_x still advances.
//  - Line of 1279 bytes -> 639 writes, trailing byte dropped, one line_err at href fall.
//  - Frame of 479 lines then vs rise -> frame_done and frame_err pulse same cycle.
//  - rst asserted mid-line (pixel 300) -> next cycle all outputs 0, state S_SKIP, no writes
//    until SKIP_FRAMES+1 vs rises seen.

Source files
------------

// File: rtl/ov7670_capture_fifo_writer_pkg.sv
// Shared definitions for the OV7670 capture path and the VGA timing core.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package ov7670_capture_fifo_writer_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        S_SKIP    = 2'd0,
        S_VSYNC   = 2'd1,
        S_CAPTURE = 2'd2
    } cap_state_t;

    // Frame geometry shared with the VGA timing core
    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    localparam int BYTE_CNT_W = 13;
    localparam int COORD_W    = 12;

    // RGB565 field layout: R in [15:11], G in [10:5], B in [4:0]
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Sensor sends the high byte first: RRRRRGGG then GGGBBBBB
    function automatic rgb565_t rgb565_from_bytes(input logic [7:0] hi, input logic [7:0] lo);
        rgb565_t px;
        px.r = hi[7:3];
        px.g = {hi[2:0], lo[7:5]};
        px.b = lo[4:0];
        return px;
    endfunction

    function automatic logic [COORD_W-1:0] sat_inc_coord(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + COORD_W'(1);
    endfunction

endpackage

// File: rtl/ov7670_capture_fifo_writer_if.sv
// Camera pins plus async-FIFO write port of the capture block.
// Latency: n/a (wiring only).
// Backpressure: full_fifo from the FIFO; the writer drops pixels, it never stalls the sensor.
interface ov7670_capture_fifo_writer_if;
    import ov7670_capture_fifo_writer_pkg::*;

    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       full_fifo;
    logic       wr_en;
    rgb565_t    dout;

    // Capture block side
    modport master (
        input  cam_vsync, cam_href, cam_data, full_fifo,
        output wr_en, dout
    );

    // Sensor/FIFO side
    modport slave (
        output cam_vsync, cam_href, cam_data, full_fifo,
        input  wr_en, dout
    );

endinterface

// File: rtl/ov7670_capture_fifo_writer_packer.sv
// Pairs sensor bytes into RGB565 words; clear forces the current byte to be a high byte.
// Latency: combinational word on the low byte cycle; the high byte is held one register.
// Backpressure: none; every valid byte is consumed.
module rgb565_byte_packer
    import ov7670_capture_fifo_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_vld,
    input  logic [7:0] byte_dat,
    output logic       word_vld,
    output rgb565_t    word
);

    logic       phase_lo;
    logic [7:0] hi_byte;
    logic       eff_lo;

    // A line start or frame restart overrides a stale phase in the same cycle
    assign eff_lo   = phase_lo & ~clear;
    assign word_vld = byte_vld & eff_lo;
    assign word     = rgb565_from_bytes(hi_byte, byte_dat);

    // Toggle byte phase and latch the high byte
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_lo <= 1'b0;
            hi_byte  <= 8'h00;
        end else if (byte_vld) begin
            phase_lo <= ~eff_lo;
            if (!eff_lo) begin
                hi_byte <= byte_dat;
            end
        end else if (clear) begin
            phase_lo <= 1'b0;
        end
    end

endmodule

// File: rtl/ov7670_capture_fifo_writer.sv
// OV7670 capture: skip settle frames, pack RGB565, write async FIFO, flag geometry errors.
// Latency: low byte at the pin on edge k -> wr_en/dout valid in the cycle after edge k+1.
// Backpressure: full_fifo drops the pixel and sets sticky overflow; the sensor is never stalled.
module ov7670_capture_fifo_writer
    import ov7670_capture_fifo_writer_pkg::*;
#(
    parameter int SKIP_FRAMES = 2,
    parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE    = V_ACTIVE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    ov7670_capture_fifo_writer_if.master cap,
    output logic [COORD_W-1:0]       pixel_x,
    output logic [COORD_W-1:0]       pixel_y,
    output logic                     capturing,
    output logic                     frame_done,
    output logic                     line_err,
    output logic                     frame_err,
    output logic                     overflow
);

    localparam int                    SKIP_W      = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [SKIP_W-1:0]     SKIP_LAST   = SKIP_W'(SKIP_FRAMES);
    localparam logic [BYTE_CNT_W-1:0] LINE_BYTES  = BYTE_CNT_W'(2 * H_ACTIVE);
    localparam logic [COORD_W-1:0]    FRAME_LINES = COORD_W'(V_ACTIVE);

    logic                  vs_q, vs_qq, href_q, href_qq;
    logic [7:0]            data_q;
    cap_state_t            state, state_nxt;
    logic [SKIP_W-1:0]     skip_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_CNT_W-1:0] cnt_base;
    logic [COORD_W-1:0]    pix_idx;
    logic                  vs_rise, href_rise, href_fall;
    logic                  in_cap, byte_vld, pk_clear, word_vld;
    rgb565_t               word;

    // Single register stage on the sensor pins plus edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            href_q  <= 1'b0;
            href_qq <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            vs_q    <= cap.cam_vsync;
            vs_qq   <= vs_q;
            href_q  <= cap.cam_href;
            href_qq <= href_q;
            data_q  <= cap.cam_data;
        end
    end

    assign vs_rise   = vs_q & ~vs_qq;
    assign href_rise = href_q & ~href_qq;
    assign href_fall = ~href_q & href_qq;
    assign in_cap    = (state == S_CAPTURE);
    assign capturing = in_cap;

    // Frame boundary beats any href activity in the same cycle
    assign byte_vld = in_cap & href_q & ~vs_rise;
    assign pk_clear = ~in_cap | vs_rise | href_rise;

    // Byte count restarts on the first byte of a line
    assign cnt_base = href_rise ? '0 : byte_cnt;
    assign pix_idx  = cnt_base[BYTE_CNT_W-1:1];

    rgb565_byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pk_clear),
        .byte_vld (byte_vld),
        .byte_dat (data_q),
        .word_vld (word_vld),
        .word     (word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_SKIP:    if (vs_rise && skip_cnt == SKIP_LAST) state_nxt = S_VSYNC;
            S_VSYNC:   if (!vs_q) state_nxt = S_CAPTURE;
            S_CAPTURE: if (vs_rise) state_nxt = S_VSYNC;
            default:   state_nxt = S_SKIP;
        endcase
    end

    // Counters, FIFO write, pixel coordinates and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt   <= '0;
            byte_cnt   <= '0;
            pixel_x    <= '0;
            pixel_y    <= '0;
            cap.wr_en  <= 1'b0;
            cap.dout   <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            cap.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_SKIP && vs_rise && skip_cnt != SKIP_LAST) begin
                skip_cnt <= skip_cnt + SKIP_W'(1);
            end

            if (state == S_VSYNC) begin
                pixel_y  <= '0;
                byte_cnt <= '0;
            end

            if (byte_vld) begin
                byte_cnt <= (&cnt_base) ? cnt_base : cnt_base + BYTE_CNT_W'(1);
                if (word_vld) begin
                    pixel_x <= pix_idx;
                    if (cap.full_fifo) begin
                        overflow <= 1'b1;
                    end else begin
                        cap.wr_en <= 1'b1;
                        cap.dout  <= word;
                    end
                end
            end else if (in_cap && !vs_rise && href_fall) begin
                // A trailing unpaired high byte simply never gets written
                if (byte_cnt != LINE_BYTES) begin
                    line_err <= 1'b1;
                end
                pixel_y <= sat_inc_coord(pixel_y);
            end

            if (in_cap && vs_rise) begin
                frame_done <= 1'b1;
                frame_err  <= (pixel_y != FRAME_LINES);
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_fifo_writer.sv
// Randomized bench for the OV7670 capture writer with a pixel-level reference model.
// Latency: n/a.
// Backpressure: full_fifo driven per pixel by the stimulus.
module tb_ov7670_capture_fifo_writer;

    localparam int SKIP = 2;
    localparam int H    = 8;
    localparam int V    = 4;

    typedef struct {
        logic [15:0] px;
        int unsigned x;
    } exp_wr_t;

    typedef struct {
        bit          err;
        int unsigned lines;
    } exp_fr_t;

    logic        clk;
    logic        rst;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        capturing;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic        overflow;

    ov7670_capture_fifo_writer_if io ();

    ov7670_capture_fifo_writer #(
        .SKIP_FRAMES (SKIP),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap        (io),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .capturing  (capturing),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    int          n_fd  = 0;

    exp_wr_t     wq[$];
    exp_fr_t     fq[$];
    int unsigned lq[$];
    logic [7:0]  preset[$];

    int          vs_seen = 0;
    int unsigned lines   = 0;
    exp_wr_t     ew;
    exp_fr_t     ef;
    int unsigned el;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen with nothing expected", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        if (io.wr_en) begin
            n_wr++;
            if (wq.size() == 0) begin
                unexpected("unexpected_write");
            end else begin
                ew = wq.pop_front();
                chk("dout", {16'd0, io.dout}, {16'd0, ew.px});
                chk("pixel_x", {20'd0, pixel_x}, ew.x);
            end
        end
        if (frame_done) begin
            n_fd++;
            if (fq.size() == 0) begin
                unexpected("unexpected_frame_done");
            end else begin
                ef = fq.pop_front();
                chk("frame_err", {31'd0, frame_err}, {31'd0, ef.err});
                chk("pixel_y_at_frame_done", {20'd0, pixel_y}, ef.lines);
            end
        end else if (frame_err) begin
            unexpected("frame_err_without_done");
        end
        if (line_err) begin
            if (lq.size() == 0) begin
                unexpected("unexpected_line_err");
            end else begin
                el = lq.pop_front();
                chk("pixel_y_at_line_err", {20'd0, pixel_y}, el);
            end
        end
    end

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        io.cam_vsync = vs;
        io.cam_href  = hr;
        io.cam_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_vsync();
        if (vs_seen > SKIP) begin
            fq.push_back('{err: (lines != V), lines: lines});
        end
        vs_seen++;
        lines = 0;
        io.full_fifo = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
    endtask

    // full_fifo is set with each low byte and held through the DUT's decision cycle
    task automatic send_line(input int nbytes, input int f_lo, input int f_hi,
                             input int unsigned f_pct, input bit cut);
        logic [7:0] hi_b;
        logic [7:0] b;
        bit         fl;
        bit         cap_on;
        int         p;
        cap_on = (vs_seen > SKIP);
        hi_b   = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (preset.size() > 0) b = preset.pop_front();
            else b = 8'($urandom);
            if (i % 2 == 0) begin
                hi_b = b;
            end else begin
                p  = i / 2;
                fl = (p >= f_lo && p <= f_hi) || ($urandom_range(99) < f_pct);
                io.full_fifo = fl;
                if (cap_on && !fl) wq.push_back('{px: {hi_b, b}, x: p});
            end
            cyc(1'b0, 1'b1, b);
        end
        if (!cut) begin
            if (cap_on) begin
                lines++;
                if (nbytes != 2 * H) lq.push_back(lines);
            end
            repeat (3) cyc(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, io.wr_en}, 0);
        chk({tag, "_dout"}, {16'd0, io.dout}, 0);
        chk({tag, "_pixel_x"}, {20'd0, pixel_x}, 0);
        chk({tag, "_pixel_y"}, {20'd0, pixel_y}, 0);
        chk({tag, "_capturing"}, {31'd0, capturing}, 0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        chk({tag, "_line_err"}, {31'd0, line_err}, 0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 0);
        chk({tag, "_overflow"}, {31'd0, overflow}, 0);
    endtask

    int snap;
    int nl;
    int nb;

    initial begin
        rst          = 1'b1;
        io.cam_vsync = 1'b0;
        io.cam_href  = 1'b0;
        io.cam_data  = 8'h00;
        io.full_fifo = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cyc(1'b0, 1'b0, 8'h00);

        // Two settle frames with busy FIFO: nothing may be written or flagged
        for (int f = 0; f < SKIP; f++) begin
            send_vsync();
            for (int l = 0; l < V; l++) send_line(2 * H, 1000, 0, 40, 1'b0);
            chk("capturing_in_skip", {31'd0, capturing}, 0);
        end

        // First captured frame, known colours first
        send_vsync();
        snap = n_wr;
        preset.push_back(8'hF8); preset.push_back(8'h1F);
        preset.push_back(8'h07); preset.push_back(8'hE0);
        for (int l = 0; l < V; l++) send_line(2 * H, 1000, 0, 0, 1'b0);
        chk("capturing_in_frame", {31'd0, capturing}, 1);
        send_vsync();
        chk("frame2_writes", n_wr - snap, H * V);
        chk("frame2_done_count", n_fd, 1);
        chk("overflow_before_full", {31'd0, overflow}, 0);

        // Drops on pixels 2..4 of line 0, then a line one byte short
        send_line(2 * H, 2, 4, 0, 1'b0);
        send_line(2 * H - 1, 1000, 0, 0, 1'b0);
        send_line(2 * H, 1000, 0, 0, 1'b0);
        send_line(2 * H, 1000, 0, 0, 1'b0);
        send_vsync();
        chk("overflow_set", {31'd0, overflow}, 1);

        // Short frame
        for (int l = 0; l < V - 1; l++) send_line(2 * H, 1000, 0, 0, 1'b0);
        send_vsync();
        chk("overflow_sticky", {31'd0, overflow}, 1);

        // Reset in the middle of a line, with a high byte pending
        send_line(2 * 3 + 1, 1000, 0, 0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 8'hAA);
        @(negedge clk);
        check_zero("midline_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        vs_seen = 0;
        lines   = 0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Random geometry and backpressure, including the post-reset skip frames
        for (int f = 0; f < 8; f++) begin
            send_vsync();
            nl = $urandom_range(V + 1, V - 1);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(3, 0))
                    0:       nb = 2 * H - 1;
                    1:       nb = 2 * H + 1;
                    2:       nb = 2 * H - 2;
                    default: nb = 2 * H;
                endcase
                if ($urandom_range(1, 0) == 1) nb = 2 * H;
                send_line(nb, 1000, 0, 20, 1'b0);
            end
        end
        send_vsync();
        repeat (4) cyc(1'b0, 1'b0, 8'h00);

        chk("pending_writes", wq.size(), 0);
        chk("pending_frames", fq.size(), 0);
        chk("pending_line_errs", lq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
